// File: rtl/cnn_pkg.sv
// Shared CNN definitions: sequencer FSM states, FP32 constants and index-width helper.
package cnn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } tanh_seq_state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Row/column index width; a 1x1 map still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tanh_seq_idx_cnt.sv
// Row/column index counter, row-major with column fastest; wraps (N-1,N-1) -> (0,0).
module tanh_seq_idx_cnt
  import cnn_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = idx_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] row_o,
  output logic [AW-1:0] col_o,
  output logic          last_o
);

  localparam logic [AW-1:0] MaxIdx = AW'(N - 1);

  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;

  // Next index; clear wins over increment.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == MaxIdx) begin
        col_d = '0;
        row_d = (row_q == MaxIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == MaxIdx) && (col_q == MaxIdx);

endmodule

// File: rtl/tanh_seq_ctrl.sv
// Streams one IMAGE_SIZE x IMAGE_SIZE FP32 map through a shared scalar tanh core,
// one element per cycle, retiring results in order. Optional busy-cycle counter
// output cycle_count is built when TANH_SEQ_PERF_EN is defined.
module tanh_seq_ctrl
  import cnn_pkg::*;
#(
  parameter  int unsigned DATAWIDTH    = 32,
  parameter  int unsigned IMAGE_SIZE   = 4,
  parameter  int unsigned TANH_LATENCY = 3,
  localparam int unsigned AW           = idx_width(IMAGE_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_row,
  output logic [AW-1:0]        rd_col,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic                 core_in_valid,
  output logic [DATAWIDTH-1:0] core_in_data,
  input  logic                 core_out_valid,
  input  logic [DATAWIDTH-1:0] core_out_data,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_row,
  output logic [AW-1:0]        wr_col,
  output logic [DATAWIDTH-1:0] wr_data
`ifdef TANH_SEQ_PERF_EN
  ,
  output logic [15:0]          cycle_count
`endif
);

  localparam int unsigned NN = IMAGE_SIZE * IMAGE_SIZE;
  localparam int unsigned CW = $clog2(NN + 1);

  // A zero-latency core would answer in the issue cycle, before the operand is counted.
  if (TANH_LATENCY == 0) begin : g_bad_latency
    $error("TANH_LATENCY must be at least 1");
  end

  tanh_seq_state_t state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rd_en_q, rd_en_d;
  logic            civ_q;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   retired_q, retired_d;
  logic            start_acc;
  logic            issue_last;
  logic            retire_last;
  logic            wr_en_w;

  assign start_acc = (state_q == StIdle) && start;

  // Only results with an operand still outstanding at the core are retired.
  assign wr_en_w = core_out_valid && (retired_q < issued_q);

  tanh_seq_idx_cnt #(
    .N  (IMAGE_SIZE),
    .AW (AW)
  ) u_issue_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start_acc),
    .inc_i  (rd_en_q),
    .row_o  (rd_row),
    .col_o  (rd_col),
    .last_o (issue_last)
  );

  tanh_seq_idx_cnt #(
    .N  (IMAGE_SIZE),
    .AW (AW)
  ) u_retire_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start_acc),
    .inc_i  (wr_en_w),
    .row_o  (wr_row),
    .col_o  (wr_col),
    .last_o (retire_last)
  );

  // FSM next state, registered strobes, outstanding-operand bookkeeping and sticky err.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = rd_en_q;
    err_d     = err_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    if (civ_q) issued_d = issued_q + 1'b1;
    if (wr_en_w) retired_d = retired_q + 1'b1;
    if (core_out_valid && !wr_en_w) err_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          err_d     = 1'b0;
          issued_d  = '0;
          retired_d = '0;
        end
      end
      StRun: begin
        if (issue_last) begin
          state_d = StDrain;
          rd_en_d = 1'b0;
        end
      end
      StDrain: begin
        // Leave on the edge that retires the final element so done follows directly.
        if (wr_en_w && retire_last) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      civ_q     <= 1'b0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      civ_q     <= rd_en_q;
      issued_q  <= issued_d;
      retired_q <= retired_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rd_en         = rd_en_q;
  assign core_in_valid = civ_q;
  assign core_in_data  = rd_data;
  assign wr_en         = wr_en_w;
  assign wr_data       = core_out_data;

`ifdef TANH_SEQ_PERF_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  // Busy-cycle count, saturating so long runs never wrap.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (start_acc) begin
      cyc_cnt_d = '0;
    end else if (busy_q && (cyc_cnt_q != 16'hFFFF)) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;
    end
  end

  // Busy-cycle count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_cnt_q <= '0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign cycle_count = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_tanh_seq_ctrl.sv
// Bench for tanh_seq_ctrl: timing-window model checked every cycle plus directed scenarios.
module tb_tanh_seq_ctrl;
  import cnn_pkg::*;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        spur = 1'b0;

  logic        busy, done, err, rd_en, core_in_valid, core_out_valid, wr_en;
  logic [1:0]  rd_row, rd_col, wr_row, wr_col;
  logic [31:0] rd_data = '0;
  logic [31:0] core_in_data, core_out_data, wr_data;
  logic [15:0] cycle_count;

  logic        busy1, done1, err1, rd_en1, civ1, wr_en1;
  logic [0:0]  rd_row1, rd_col1, wr_row1, wr_col1;
  logic [31:0] rd_data1 = '0;
  logic [31:0] cid1, wr_data1;
  logic        cov1 = 1'b0;
  logic [31:0] cod1 = '0;
  logic [15:0] cycle_count1;

  logic [31:0] mem [NN];
  localparam logic [31:0] Mem1Word = 32'hBF80_0000;

  logic [L-1:0] cv_pipe = '0;
  logic [31:0]  cd_pipe [L];

  always #5 clk = ~clk;

  tanh_seq_ctrl #(.DATAWIDTH(32), .IMAGE_SIZE(N), .TANH_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .core_in_valid(core_in_valid), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
`ifdef TANH_SEQ_PERF_EN
    , .cycle_count(cycle_count)
`endif
  );

  tanh_seq_ctrl #(.DATAWIDTH(32), .IMAGE_SIZE(1), .TANH_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .err(err1),
    .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1), .rd_data(rd_data1),
    .core_in_valid(civ1), .core_in_data(cid1),
    .core_out_valid(cov1), .core_out_data(cod1),
    .wr_en(wr_en1), .wr_row(wr_row1), .wr_col(wr_col1), .wr_data(wr_data1)
`ifdef TANH_SEQ_PERF_EN
    , .cycle_count(cycle_count1)
`endif
  );

`ifndef TANH_SEQ_PERF_EN
  assign cycle_count  = '0;
  assign cycle_count1 = '0;
`endif

  // Input buffers (one-cycle read latency) and identity cores with fixed latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[{rd_row, rd_col}];
    if (rd_en1) rd_data1 <= Mem1Word;
    cv_pipe <= {cv_pipe[L-2:0], core_in_valid};
    cd_pipe[0] <= core_in_data;
    for (int i = 1; i < L; i++) cd_pipe[i] <= cd_pipe[i-1];
    cov1 <= civ1;
    cod1 <= cid1;
  end
  assign core_out_valid = cv_pipe[L-1] | spur;
  assign core_out_data  = cd_pipe[L-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int rst_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  always @(posedge reset) rst_cnt++;

  // Model state: pass start edge, sticky err and busy-cycle count.
  bit          pass_v = 1'b0;
  int          pass_s = 0;
  bit          err_m = 1'b0;
  logic [15:0] cc_m = '0;
  int          rel;
  bit          e_rd, e_civ, e_wr, e_busy, e_done, idle;

  // Observation logs for the directed checks.
  int          rd_cyc[$];
  int          wr_cyc[$];
  logic [31:0] wr_dat[$];
  int          done_cyc[$];
  int          busy_total = 0;
  int          rd1_cyc = -1, wr1_cyc = -1, done1_cyc = -1, rd1_n = 0, wr1_n = 0;
  logic [1:0]  wr1_rc = '1;
  logic [31:0] wr1_dat = '0;

  // Per-cycle comparison against the timing-window model (cycle c ends at edge c).
  always @(negedge clk) begin
    cyc++;
    if (rst_cnt != rst_seen) begin
      rst_seen = rst_cnt;
      pass_v   = 1'b0;
      err_m    = 1'b0;
      cc_m     = '0;
    end
    rel    = pass_v ? cyc - pass_s : -1000;
    e_rd   = (rel >= 1) && (rel <= NN);
    e_civ  = (rel >= 2) && (rel <= NN + 1);
    e_wr   = (rel >= L + 2) && (rel <= L + 1 + NN);
    e_busy = (rel >= 1) && (rel <= NN + L + 1);
    e_done = (rel == NN + L + 2);

    if (rd_en) rd_cyc.push_back(cyc);
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(wr_data);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_total++;
    if (rd_en1) begin
      rd1_n++;
      if (rd1_cyc < 0) rd1_cyc = cyc;
    end
    if (wr_en1) begin
      wr1_n++;
      if (wr1_cyc < 0) begin
        wr1_cyc = cyc;
        wr1_rc  = {wr_row1, wr_col1};
        wr1_dat = wr_data1;
      end
    end
    if (done1 && done1_cyc < 0) done1_cyc = cyc;

    if (reset) begin
      pass_v = 1'b0;
      err_m  = 1'b0;
      cc_m   = '0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_core_in_valid", 32'(core_in_valid), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_rd_idx", 32'({rd_row, rd_col}), 0);
      chk("rst_wr_idx", 32'({wr_row, wr_col}), 0);
      chk("rst_cycle_count", 32'(cycle_count), 0);
    end else begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(err_m));
      chk("rd_en", 32'(rd_en), 32'(e_rd));
      chk("core_in_valid", 32'(core_in_valid), 32'(e_civ));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      if (e_rd) begin
        chk("rd_row", 32'(rd_row), (rel - 1) / N);
        chk("rd_col", 32'(rd_col), (rel - 1) % N);
      end
      if (e_civ) chk("core_in_data", core_in_data, mem[rel-2]);
      if (e_wr) begin
        chk("wr_row", 32'(wr_row), (rel - L - 2) / N);
        chk("wr_col", 32'(wr_col), (rel - L - 2) % N);
        chk("wr_data", wr_data, mem[rel-L-2]);
      end
`ifdef TANH_SEQ_PERF_EN
      chk("cycle_count", 32'(cycle_count), 32'(cc_m));
`endif
      // Advance the model across the coming edge.
      idle = !pass_v || (rel >= NN + L + 3);
      if (idle && start) begin
        pass_v = 1'b1;
        pass_s = cyc;
        err_m  = 1'b0;
        cc_m   = '0;
      end else begin
        if (core_out_valid && !e_wr) err_m = 1'b1;
        if (e_busy && cc_m != 16'hFFFF) cc_m = cc_m + 16'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int k, nrd, nwr, ndone, nbusy;

  initial begin
    for (int i = 0; i < NN; i++) mem[i] = {8'hC1, 8'(i * 17), 16'hA5A5};
    mem[0] = FP_ZERO;
    mem[4] = FP_ONE;

    step(3);
    reset = 1'b0;
    step(2);

    // Single start pulse: write window, data and done timing.
    k = cyc + 1; nrd = rd_cyc.size(); nwr = wr_cyc.size();
    ndone = done_cyc.size(); nbusy = busy_total;
    start = 1'b1; step(1); start = 1'b0;
    step(NN + L + 4);
    chk("p1_first_rd", qget(rd_cyc, nrd), k + 1);
    chk("p1_first_wr", qget(wr_cyc, nwr), k + 5);
    chk("p1_last_wr", qget(wr_cyc, nwr + 15), k + 20);
    chk("p1_wr_count", wr_cyc.size() - nwr, 16);
    chk("p1_wr_elem_1_0", (wr_dat.size() > nwr + 4) ? wr_dat[nwr+4] : 32'hDEAD_BEEF, 32'h3F80_0000);
    chk("p1_done_count", done_cyc.size() - ndone, 1);
    chk("p1_done_cycle", qget(done_cyc, ndone), k + 21);
    chk("p1_busy_cycles", busy_total - nbusy, 20);
`ifdef TANH_SEQ_PERF_EN
    chk("perf_after_done", 32'(cycle_count), 20);
    step(5);
    chk("perf_hold", 32'(cycle_count), 20);
`endif

    // Start held for 40 cycles: exactly two back-to-back passes.
    k = cyc + 1; nrd = rd_cyc.size(); ndone = done_cyc.size();
    start = 1'b1; step(40); start = 1'b0;
    step(30);
    chk("held_done_count", done_cyc.size() - ndone, 2);
    chk("held_rd_count", rd_cyc.size() - nrd, 32);
    chk("held_first_done", qget(done_cyc, ndone), k + 21);
    chk("held_second_rd", qget(rd_cyc, nrd + 16), qget(done_cyc, ndone) + 2);

    // Spurious core result in IDLE sets err without a write; start then clears it.
    nwr = wr_cyc.size();
    spur = 1'b1; step(1); spur = 1'b0; step(1);
    chk("spur_err", 32'(err), 1);
    chk("spur_no_write", wr_cyc.size() - nwr, 0);
    ndone = done_cyc.size();
    start = 1'b1; step(1); start = 1'b0;
    chk("spur_err_cleared", 32'(err), 0);
    step(NN + L + 4);
    chk("spur_pass_writes", wr_cyc.size() - nwr, 16);
    chk("spur_pass_done", done_cyc.size() - ndone, 1);

    // Reset in the middle of a pass; late core results then flag err.
    k = cyc + 1;
    start = 1'b1; step(1); start = 1'b0;
    step(7);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rd_en", 32'(rd_en), 0);
    chk("mid_rst_civ", 32'(core_in_valid), 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_rd_idx", 32'({rd_row, rd_col}), 0);
    #1;
    reset = 1'b0;
    nwr = wr_cyc.size();
    step(6);
    chk("straggler_err", 32'(err), 1);
    chk("straggler_no_write", wr_cyc.size() - nwr, 0);
    ndone = done_cyc.size();
    start = 1'b1; step(1); start = 1'b0;
    step(NN + L + 4);
    chk("post_rst_writes", wr_cyc.size() - nwr, 16);
    chk("post_rst_done", done_cyc.size() - ndone, 1);
    chk("post_rst_err", 32'(err), 0);

    // 1x1 map with a single-cycle core.
    k = cyc + 1;
    start1 = 1'b1; step(1); start1 = 1'b0;
    step(6);
    chk("n1_rd_cycle", rd1_cyc, k + 1);
    chk("n1_rd_count", rd1_n, 1);
    chk("n1_wr_cycle", wr1_cyc, k + 3);
    chk("n1_wr_count", wr1_n, 1);
    chk("n1_wr_idx", 32'(wr1_rc), 0);
    chk("n1_wr_data", wr1_dat, Mem1Word);
    chk("n1_done_cycle", done1_cyc, k + 4);
    chk("n1_err", 32'(err1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tanh_seq_ctrl.md
# tanh_seq_ctrl

Sequencer that streams one IMAGE_SIZE x IMAGE_SIZE feature map of IEEE-754 single-precision words through a single shared scalar tanh core. It replaces the fully parallel 2D tanh array in area-constrained layers of the CNN. It sits between the layer's input feature buffer, the scalar tanh core and the output feature buffer. It issues one element per cycle, retires results in order and signals completion with a one-cycle done pulse.

## Interface
- DATAWIDTH, 32, word width (IEEE-754 single).
- IMAGE_SIZE, 4, feature-map side; N = IMAGE_SIZE, total elements N*N.
- TANH_LATENCY, 3, fixed cycles from core_in_valid to core_out_valid; minimum 1.
- AW, $clog2(IMAGE_SIZE), row/column index width (localparam; 1 when IMAGE_SIZE=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one map pass; sampled only in IDLE.
- busy  out  1  high from the first issue cycle through the last write cycle.
- done  out  1  one-cycle pulse after the last write.
- err  out  1  sticky; set on an unexpected core_out_valid; cleared only by reset or by accepted start.
- rd_en  out  1  input buffer read strobe.
- rd_row, rd_col  out  AW  input element index.
- rd_data  in  DATAWIDTH  input word, valid the cycle after rd_en.
- core_in_valid  out  1  operand valid to tanh core.
- core_in_data  out  DATAWIDTH  operand (registered rd_data path).
- core_out_valid  in  1  core result valid.
- core_out_data  in  DATAWIDTH  core result.
- wr_en  out  1  output buffer write strobe.
- wr_row, wr_col  out  AW  output element index.
- wr_data  out  DATAWIDTH  result word.
- cycle_count  out  16  only with TANH_SEQ_PERF_EN (see Configuration).

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN: on a start edge. Both counters and err clear.
- RUN: issue counter (row-major, col fastest) drives rd_en=1 and rd_row/rd_col every cycle. After issuing element N*N-1 the FSM goes to DRAIN.
- DRAIN: rd_en=0. The FSM waits until the retire counter reaches N*N.
- DONE: done=1 for exactly one cycle, then IDLE.
- core_in_valid is rd_en delayed 1 cycle. core_in_data equals rd_data in that cycle (wire-through; no extra register).
- Retire path, in order:
  - wr_en = core_out_valid && (retired < issued_to_core).
  - wr_data = core_out_data.
  - wr_row/wr_col come from the retire counter, which increments on wr_en.
- If core_out_valid arrives when no operation is outstanding (or in IDLE): err is set, nothing is written, and counters are unchanged.
- start asserted outside IDLE is ignored. A held start causes a back-to-back pass only after DONE returns to IDLE.
- Counters: linear issue/retire counts are $clog2(N*N+1) bits wide. Row/col wrap col N-1 -> 0 with row+1, and never exceed N-1.
- Reset mid-pass: all outputs return to 0 immediately and the FSM goes to IDLE. In-flight core results that arrive afterwards set err. The bench must reset the core too.

## Timing
- Reset values: busy=0, done=0, err=0, rd_en=0, core_in_valid=0, wr_en=0, all indices 0, cycle_count=0.
- start is sampled at edge k. The first rd_en is in cycle k+1, the first core_in_valid in k+2, the first wr_en in k+2+TANH_LATENCY.
- The last rd_en is in cycle k+N*N and the last wr_en in k+1+N*N+TANH_LATENCY. done fires in k+2+N*N+TANH_LATENCY.
- Throughput is 1 element/cycle with no bubbles. Pass length is N*N+TANH_LATENCY+2 cycles from start to done.

## Configuration
- TANH_SEQ_PERF_EN defined: the cycle_count port exists. It clears on accepted start, increments every cycle while busy, and saturates at 16'hFFFF. It holds its value after done until the next start.
- TANH_SEQ_PERF_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package cnn_pkg holds:
  - the FSM state enum tanh_seq_state_t;
  - FP32 constants FP_ONE (32'h3F800000) and FP_ZERO;
  - the index-width helper function.
- One sub-module is natural: tanh_seq_idx_cnt, a row/col wrapping counter with clear/inc and a last flag. It is instantiated twice, once for issue and once for retire.

## Test plan
- N=4, L=3, start pulse at edge k, with a bench core that delays its input by 3 cycles and returns it unchanged. Required response:
  - 16 writes in cycles k+5..k+20, in row-major order;
  - wr_data equals the input buffer, e.g. element (1,0)=32'h3F800000;
  - done only in k+21;
  - busy high for k+1..k+20.
- Start held high for 40 cycles -> exactly two passes; the second pass's first rd_en comes one cycle after DONE returns to IDLE.
- Spurious core_out_valid in IDLE -> err=1, no wr_en. Then a start -> err clears and the pass completes normally.
- Reset asserted at cycle k+8 -> all outputs 0 asynchronously. The straggler results in k+9..k+11 set err. A new pass then completes with 16 writes.
- N=1, L=1 -> rd_en in k+1, wr_en in k+3 at (0,0), done in k+4.
- TANH_SEQ_PERF_EN with N=4, L=3 -> cycle_count=20 after done, and it holds at 20 until the next start.
